// File: rtl/rx_ltssm.sv
// rx_ltssm: receive-side LTSSM companion.
// Watches ordered sets from the RX OS decoder, counts consecutive ones
// that satisfy the exit condition of the commanded training state, and
// reports a one-cycle finish pulse plus the exit state to the main LTSSM.
// A per-state timer forces an exit to DetectQuiet when training stalls.
// Upstream ports also capture the link number proposed downstream.
//
// state              | meaning
// -------------------+----------------------------------------------
// DetectQuiet   (0)  | passive, no counting
// DetectActive  (1)  | passive, no counting
// PollingActive (2)  | 8 TS1/TS2 with PAD link+lane -> PollingCfg
// PollingCfg    (3)  | 8 TS2 -> CfgLinkWidthStart
// CfgLwStart    (4)  | 2 TS1 with non-PAD link -> CfgLwAccept
// CfgLwAccept   (5)  | 2 TS1, stored link, non-PAD lane -> CfgLnWait
// CfgLnWait     (6)  | 2 TS1, stored link -> CfgLnActive
// CfgLnActive   (7)  | 2 TS2, stored link -> CfgComplete
// CfgComplete   (8)  | 8 TS2, stored link -> CfgIdle
// CfgIdle       (9)  | 8 IDLE -> L0
// L0            (A)  | passive, no counting
// Idle          (F)  | passive, no counting (reset state)

module rx_ltssm #(
  parameter int unsigned DEVICETYPE     = 0,
  parameter int unsigned LANESNUMBER    = 16,
  parameter logic [7:0]  PAD            = 8'hF7,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6000000
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic [3:0] SetRXState,
  output logic       RXFinishFlag,
  output logic [3:0] RXExitTo,
  input  logic       OSValid,
  input  logic [2:0] OSType,
  input  logic [7:0] RxLinkNum,
  input  logic [7:0] RxLaneNum,
  input  logic [7:0] ReadLinkNum,
  output logic [7:0] WriteLinkNum,
  output logic       WriteLinkNumFlag
);

  typedef enum logic [3:0] {
    ST_DETECT_QUIET  = 4'h0,
    ST_DETECT_ACTIVE = 4'h1,
    ST_POLL_ACTIVE   = 4'h2,
    ST_POLL_CFG      = 4'h3,
    ST_CFG_LW_START  = 4'h4,
    ST_CFG_LW_ACCEPT = 4'h5,
    ST_CFG_LN_WAIT   = 4'h6,
    ST_CFG_LN_ACTIVE = 4'h7,
    ST_CFG_COMPLETE  = 4'h8,
    ST_CFG_IDLE      = 4'h9,
    ST_L0            = 4'hA,
    ST_IDLE          = 4'hF
  } state_e;

  localparam logic [2:0] OS_TS1  = 3'b000;
  localparam logic [2:0] OS_TS2  = 3'b001;
  localparam logic [2:0] OS_IDLE = 3'b100;

  // Only lane 0 is observed; a zero-lane build has nothing to train.
  localparam logic LANES_OK     = (LANESNUMBER != 0);
  localparam logic CAPTURE_LINK = (DEVICETYPE == 1);

  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

  state_e      state_q, state_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [23:0] timer_q, timer_d;
  logic        done_q, done_d;
  logic        finish_q, finish_d;
  logic [3:0]  exit_q, exit_d;
  logic [7:0]  wlink_q, wlink_d;
  logic        wflag_q, wflag_d;

  logic        transition;
  logic        training;
  logic        os_match;
  logic [3:0]  req_n;
  state_e      exit_st;
  logic        capture_here;
  logic [3:0]  cnt_inc;
  logic        match_hit;
  logic        timeout_hit;

  logic is_ts1, is_ts2, is_idle;
  logic link_pad, lane_pad, link_stored;

  assign is_ts1      = (OSType == OS_TS1);
  assign is_ts2      = (OSType == OS_TS2);
  assign is_idle     = (OSType == OS_IDLE);
  assign link_pad    = (RxLinkNum == PAD);
  assign lane_pad    = (RxLaneNum == PAD);
  assign link_stored = (RxLinkNum == ReadLinkNum);

  assign transition  = (SetRXState != state_q);
  assign cnt_inc     = (match_cnt_q == 4'hF) ? 4'hF : match_cnt_q + 4'd1;
  assign match_hit   = OSValid && os_match && (cnt_inc == req_n);
  assign timeout_hit = (timer_q == TIMEOUT_LAST);

  // Per-state exit condition: which OS qualifies, how many, and where to go.
  always_comb begin
    training     = 1'b0;
    os_match     = 1'b0;
    req_n        = 4'd0;
    exit_st      = ST_DETECT_QUIET;
    capture_here = 1'b0;
    case (state_q)
      ST_POLL_ACTIVE: begin
        training = 1'b1;
        os_match = (is_ts1 || is_ts2) && link_pad && lane_pad;
        req_n    = 4'd8;
        exit_st  = ST_POLL_CFG;
      end
      ST_POLL_CFG: begin
        training = 1'b1;
        os_match = is_ts2;
        req_n    = 4'd8;
        exit_st  = ST_CFG_LW_START;
      end
      ST_CFG_LW_START: begin
        training     = 1'b1;
        os_match     = is_ts1 && !link_pad;
        req_n        = 4'd2;
        exit_st      = ST_CFG_LW_ACCEPT;
        capture_here = CAPTURE_LINK;
      end
      ST_CFG_LW_ACCEPT: begin
        training = 1'b1;
        os_match = is_ts1 && link_stored && !lane_pad;
        req_n    = 4'd2;
        exit_st  = ST_CFG_LN_WAIT;
      end
      ST_CFG_LN_WAIT: begin
        training = 1'b1;
        os_match = is_ts1 && link_stored;
        req_n    = 4'd2;
        exit_st  = ST_CFG_LN_ACTIVE;
      end
      ST_CFG_LN_ACTIVE: begin
        training = 1'b1;
        os_match = is_ts2 && link_stored;
        req_n    = 4'd2;
        exit_st  = ST_CFG_COMPLETE;
      end
      ST_CFG_COMPLETE: begin
        training = 1'b1;
        os_match = is_ts2 && link_stored;
        req_n    = 4'd8;
        exit_st  = ST_CFG_IDLE;
      end
      ST_CFG_IDLE: begin
        training = 1'b1;
        os_match = is_idle;
        req_n    = 4'd8;
        exit_st  = ST_L0;
      end
      default: begin
        training = 1'b0;
      end
    endcase
  end

  // Next-state: follow the commanded state, count matches and time, raise pulses.
  always_comb begin
    state_d     = state_e'(SetRXState);
    match_cnt_d = match_cnt_q;
    timer_d     = timer_q;
    done_d      = done_q;
    finish_d    = 1'b0;
    exit_d      = exit_q;
    wlink_d     = wlink_q;
    wflag_d     = 1'b0;

    if (transition) begin
      // A new state starts from scratch; an OS arriving now belongs to neither state.
      match_cnt_d = 4'd0;
      timer_d     = 24'd0;
      done_d      = 1'b0;
    end else if (training && LANES_OK && !done_q) begin
      timer_d = timer_q + 24'd1;
      if (OSValid) begin
        match_cnt_d = os_match ? cnt_inc : 4'd0;
      end
      // A match completing on the timeout cycle takes precedence.
      if (match_hit) begin
        finish_d = 1'b1;
        exit_d   = exit_st;
        done_d   = 1'b1;
        if (capture_here) begin
          wlink_d = RxLinkNum;
          wflag_d = 1'b1;
        end
      end else if (timeout_hit) begin
        finish_d = 1'b1;
        exit_d   = ST_DETECT_QUIET;
        done_d   = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= 4'd0;
      timer_q     <= 24'd0;
      done_q      <= 1'b0;
      finish_q    <= 1'b0;
      exit_q      <= 4'd0;
      wlink_q     <= 8'd0;
      wflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
      finish_q    <= finish_d;
      exit_q      <= exit_d;
      wlink_q     <= wlink_d;
      wflag_q     <= wflag_d;
    end
  end

  assign RXFinishFlag     = finish_q;
  assign RXExitTo         = exit_q;
  assign WriteLinkNum     = wlink_q;
  assign WriteLinkNumFlag = wflag_q;

endmodule

// File: tb/tb_rx_ltssm.sv
// Directed bench for rx_ltssm (upstream build, short timeout).
module tb_rx_ltssm;

  localparam logic [2:0] TS1 = 3'b000;
  localparam logic [2:0] TS2 = 3'b001;
  localparam logic [2:0] IDL = 3'b100;
  localparam logic [7:0] PADV = 8'hF7;

  logic       Pclk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] SetRXState = 4'hF;
  logic       RXFinishFlag;
  logic [3:0] RXExitTo;
  logic       OSValid = 1'b0;
  logic [2:0] OSType = 3'b000;
  logic [7:0] RxLinkNum = 8'h00;
  logic [7:0] RxLaneNum = 8'h00;
  logic [7:0] ReadLinkNum = 8'h00;
  logic [7:0] WriteLinkNum;
  logic       WriteLinkNumFlag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int wflags = 0;

  rx_ltssm #(
    .DEVICETYPE(1),
    .LANESNUMBER(16),
    .PAD(8'hF7),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .Pclk(Pclk),
    .Reset(Reset),
    .SetRXState(SetRXState),
    .RXFinishFlag(RXFinishFlag),
    .RXExitTo(RXExitTo),
    .OSValid(OSValid),
    .OSType(OSType),
    .RxLinkNum(RxLinkNum),
    .RxLaneNum(RxLaneNum),
    .ReadLinkNum(ReadLinkNum),
    .WriteLinkNum(WriteLinkNum),
    .WriteLinkNumFlag(WriteLinkNumFlag)
  );

  always #5 Pclk = ~Pclk;

  always @(posedge Pclk) cyc <= cyc + 1;

  // Count pulses mid-cycle so every one is seen regardless of stimulus timing.
  always @(negedge Pclk) begin
    if (RXFinishFlag) pulses <= pulses + 1;
    if (WriteLinkNumFlag) wflags <= wflags + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Pclk);
    #1;
  endtask

  // One OS strobe, sampled on the next edge; returns just after that edge.
  task automatic os_drive(input logic [2:0] t, input logic [7:0] lk, input logic [7:0] ln);
    OSValid = 1'b1;
    OSType = t;
    RxLinkNum = lk;
    RxLaneNum = ln;
    step(1);
    OSValid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] st;
    logic [2:0] good_t;
    logic [7:0] good_lk;
    logic [7:0] good_ln;
    logic [2:0] bad_t;
    logic [7:0] bad_lk;
    logic [7:0] bad_ln;
  } cfg_vec_t;

  cfg_vec_t vecs[3];

  int base;
  int t0;
  int elapsed;

  initial begin
    vecs[0] = '{4'h5, TS1, 8'h01, 8'h00, TS1, 8'h01, PADV};
    vecs[1] = '{4'h6, TS1, 8'h01, PADV,  TS2, 8'h01, PADV};
    vecs[2] = '{4'h7, TS2, 8'h01, PADV,  TS2, 8'h02, PADV};

    // Reset
    step(2);
    chk("rst_flag", RXFinishFlag, 0);
    chk("rst_exit", RXExitTo, 0);
    chk("rst_wflag", WriteLinkNumFlag, 0);
    chk("rst_wlink", WriteLinkNum, 0);
    Reset = 1'b1;
    step(1);

    // PollingActive: 8 PAD TS1 -> exit 3, then silent
    SetRXState = 4'h2;
    step(1);
    base = pulses;
    for (int i = 0; i < 7; i++) begin
      os_drive(TS1, PADV, PADV);
      step(3);
    end
    chk("pa_early", pulses - base, 0);
    os_drive(TS1, PADV, PADV);
    chk("pa_flag", RXFinishFlag, 1);
    chk("pa_exit", RXExitTo, 4'h3);
    step(1);
    chk("pa_width", RXFinishFlag, 0);
    step(2);
    os_drive(TS1, PADV, PADV);
    step(3);
    chk("pa_single", pulses - base, 1);

    // PollingCfg: 5 TS2, TS1 breaks the run, 8 TS2
    SetRXState = 4'h3;
    step(1);
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      os_drive(TS2, PADV, PADV);
      step(3);
    end
    os_drive(TS1, PADV, PADV);
    step(3);
    for (int i = 0; i < 7; i++) begin
      os_drive(TS2, PADV, PADV);
      step(3);
    end
    chk("pc_early", pulses - base, 0);
    os_drive(TS2, PADV, PADV);
    chk("pc_flag", RXFinishFlag, 1);
    chk("pc_exit", RXExitTo, 4'h4);
    step(3);

    // CfgLinkWidthStart upstream: link capture alongside the pulse
    ReadLinkNum = 8'h01;
    SetRXState = 4'h4;
    step(1);
    base = pulses;
    os_drive(TS1, 8'h01, PADV);
    step(3);
    os_drive(TS1, PADV, PADV);
    step(3);
    os_drive(TS1, 8'h01, PADV);
    step(3);
    chk("lw_early", pulses - base, 0);
    os_drive(TS1, 8'h01, PADV);
    chk("lw_flag", RXFinishFlag, 1);
    chk("lw_exit", RXExitTo, 4'h5);
    chk("lw_wflag", WriteLinkNumFlag, 1);
    chk("lw_wlink", WriteLinkNum, 8'h01);
    step(1);
    chk("lw_wflag_width", WriteLinkNumFlag, 0);
    step(2);

    // CfgLinkWidthAccept / LaneNumWait / LaneNumActive
    foreach (vecs[v]) begin
      SetRXState = vecs[v].st;
      step(1);
      base = pulses;
      os_drive(vecs[v].good_t, vecs[v].good_lk, vecs[v].good_ln);
      step(3);
      os_drive(vecs[v].bad_t, vecs[v].bad_lk, vecs[v].bad_ln);
      step(3);
      os_drive(vecs[v].good_t, vecs[v].good_lk, vecs[v].good_ln);
      step(3);
      chk("cfg_early", pulses - base, 0);
      os_drive(vecs[v].good_t, vecs[v].good_lk, vecs[v].good_ln);
      chk("cfg_flag", RXFinishFlag, 1);
      chk("cfg_exit", RXExitTo, 32'(vecs[v].st) + 1);
      chk("cfg_wflag", WriteLinkNumFlag, 0);
      step(3);
    end

    // CfgIdle timeout with no OS: pulse 100 cycles after entry, exit DetectQuiet
    SetRXState = 4'h9;
    step(1);
    t0 = cyc;
    base = pulses;
    for (int k = 0; k < 150; k++) begin
      step(1);
      if (RXFinishFlag) break;
    end
    elapsed = cyc - t0;
    chk("to_cycle", elapsed, 100);
    chk("to_exit", RXExitTo, 4'h0);
    step(20);
    chk("to_single", pulses - base, 1);

    // CfgIdle: 8th IDLE lands on the timeout cycle, match wins
    SetRXState = 4'h8;
    step(1);
    SetRXState = 4'h9;
    step(1);
    base = pulses;
    step(71);
    for (int i = 0; i < 7; i++) begin
      os_drive(IDL, PADV, PADV);
      step(3);
    end
    chk("tie_early", pulses - base, 0);
    os_drive(IDL, PADV, PADV);
    chk("tie_flag", RXFinishFlag, 1);
    chk("tie_exit", RXExitTo, 4'hA);
    step(3);

    // OS in the transition cycle is dropped: 8 more IDLE needed afterwards
    SetRXState = 4'h8;
    step(1);
    for (int i = 0; i < 6; i++) begin
      os_drive(TS2, 8'h01, PADV);
      step(3);
    end
    base = pulses;
    SetRXState = 4'h9;
    os_drive(IDL, PADV, PADV);
    step(3);
    for (int i = 0; i < 7; i++) begin
      os_drive(IDL, PADV, PADV);
      step(3);
    end
    chk("drop_early", pulses - base, 0);
    os_drive(IDL, PADV, PADV);
    chk("drop_flag", RXFinishFlag, 1);
    chk("drop_exit", RXExitTo, 4'hA);
    step(3);

    // Reset mid-count in CfgComplete
    SetRXState = 4'h8;
    step(1);
    for (int i = 0; i < 6; i++) begin
      os_drive(TS2, 8'h01, PADV);
      step(3);
    end
    Reset = 1'b0;
    step(1);
    chk("mid_rst_flag", RXFinishFlag, 0);
    chk("mid_rst_exit", RXExitTo, 0);
    chk("mid_rst_wlink", WriteLinkNum, 0);
    chk("mid_rst_wflag", WriteLinkNumFlag, 0);
    Reset = 1'b1;
    step(1);
    base = pulses;
    for (int i = 0; i < 7; i++) begin
      os_drive(TS2, 8'h01, PADV);
      step(3);
    end
    chk("cc_early", pulses - base, 0);
    os_drive(TS2, 8'h01, PADV);
    chk("cc_flag", RXFinishFlag, 1);
    chk("cc_exit", RXExitTo, 4'h9);
    step(3);

    chk("wflag_total", wflags, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
